// File: rtl/qsfp_port_manager.sv
// QSFP port manager: per-channel presence synchronizer and debouncer, module
// reset/initialisation sequencer, and status LED driver with a shared blink.
module qsfp_port_manager #(
    parameter int CHANNEL_COUNT   = 2,
    parameter int DEBOUNCE_CYCLES = 200_000,
    parameter int RESET_CYCLES    = 2_000,
    parameter int INIT_CYCLES     = 400_000_000,
    parameter int BLINK_CYCLES    = 50_000_000
) (
    input  logic                     system_clock,
    input  logic                     system_reset_n,
    input  logic [CHANNEL_COUNT-1:0] qsfp_modprsl,
    input  logic [CHANNEL_COUNT-1:0] reset_request,
    input  logic [CHANNEL_COUNT-1:0] run,
    output logic [CHANNEL_COUNT-1:0] hpd,
    output logic [CHANNEL_COUNT-1:0] qsfp_resetl,
    output logic [CHANNEL_COUNT-1:0] enable,
    output logic [CHANNEL_COUNT-1:0] led_y,
    output logic [CHANNEL_COUNT-1:0] led_g
);

    // Counter widths; each is at least one bit so degenerate parameters still elaborate.
    localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CNT_MAX = (RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ABSENT = 2'd0,
        ST_RESET  = 2'd1,
        ST_INIT   = 2'd2,
        ST_READY  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Shared blink generator
    // ------------------------------------------------------------------
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;

    // Free-running blink counter: flip the blink phase each time it wraps.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_d     = blink_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    // Blink state register.
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values, independent of block order.
        if (!system_reset_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel logic; channels share nothing but the blink phase.
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < CHANNEL_COUNT; ch++) begin : g_ch
        logic             sync1_q, sync2_q;
        logic             raw_present;
        logic             stable_q, stable_d;
        logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             led_y_q, led_y_d;
        logic             led_g_q, led_g_d;

        // Two-flop synchronizer on the asynchronous, active-low present pin.
        always_ff @(posedge system_clock or negedge system_reset_n) begin
            if (!system_reset_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= qsfp_modprsl[ch];
                sync2_q <= sync1_q;
            end
        end

        assign raw_present = ~sync2_q;

        // Debounce: accept a change only after it has persisted DEBOUNCE_CYCLES cycles.
        always_comb begin
            stable_d  = stable_q;
            deb_cnt_d = '0;
            if (raw_present != stable_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    stable_d = raw_present;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
        end

        // Module sequencer next state; removal overrides every other transition.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_ABSENT: begin
                    cnt_d = '0;
                    if (stable_q) state_d = ST_RESET;
                end
                ST_RESET: begin
                    if (reset_request[ch]) begin
                        cnt_d = '0;
                    end else if (cnt_q == RESET_LAST) begin
                        state_d = ST_INIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_INIT: begin
                    if (reset_request[ch]) begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
                    end else if (cnt_q == INIT_LAST) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (reset_request[ch]) begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_ABSENT;
                    cnt_d   = '0;
                end
            endcase
            if (!stable_q) begin
                state_d = ST_ABSENT;
                cnt_d   = '0;
            end
        end

        // LED decode from the registered state; registered so run has no path to the pins.
        always_comb begin
            led_y_d = 1'b0;
            led_g_d = 1'b0;
            case (state_q)
                ST_RESET, ST_INIT: led_y_d = blink_q;
                ST_READY: begin
                    led_y_d = ~run[ch];
                    led_g_d = run[ch];
                end
                default: ;
            endcase
        end

        // Channel state registers.
        always_ff @(posedge system_clock or negedge system_reset_n) begin
            if (!system_reset_n) begin
                stable_q  <= 1'b0;
                deb_cnt_q <= '0;
                state_q   <= ST_ABSENT;
                cnt_q     <= '0;
                led_y_q   <= 1'b0;
                led_g_q   <= 1'b0;
            end else begin
                stable_q  <= stable_d;
                deb_cnt_q <= deb_cnt_d;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                led_y_q   <= led_y_d;
                led_g_q   <= led_g_d;
            end
        end

        assign hpd[ch]         = stable_q;
        assign qsfp_resetl[ch] = (state_q == ST_INIT) || (state_q == ST_READY);
        assign enable[ch]      = (state_q == ST_READY);
        assign led_y[ch]       = led_y_q;
        assign led_g[ch]       = led_g_q;
    end

endmodule

// File: tb/tb_qsfp_port_manager.sv
// Scoreboard bench for qsfp_port_manager: stimulus queues the expected output
// snapshot for a given cycle, a negedge monitor pops and compares it.
module tb_qsfp_port_manager;

    localparam int NCH = 2;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] qsfp_modprsl;
    logic [NCH-1:0] reset_request;
    logic [NCH-1:0] run;
    logic [NCH-1:0] hpd;
    logic [NCH-1:0] qsfp_resetl;
    logic [NCH-1:0] enable;
    logic [NCH-1:0] led_y;
    logic [NCH-1:0] led_g;

    qsfp_port_manager #(
        .CHANNEL_COUNT  (NCH),
        .DEBOUNCE_CYCLES(4),
        .RESET_CYCLES   (3),
        .INIT_CYCLES    (5),
        .BLINK_CYCLES   (2)
    ) dut (
        .system_clock  (clk),
        .system_reset_n(rst_n),
        .qsfp_modprsl  (qsfp_modprsl),
        .reset_request (reset_request),
        .run           (run),
        .hpd           (hpd),
        .qsfp_resetl   (qsfp_resetl),
        .enable        (enable),
        .led_y         (led_y),
        .led_g         (led_g)
    );

    typedef struct {
        int       cyc;
        string    name;
        logic [1:0] hpd;
        logic [1:0] rl;
        logic [1:0] en;
        logic [1:0] ly;
        logic [1:0] lg;
        bit       chk_led;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   rel_cyc  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Queue the expected outputs for cycle cyc+dly.
    task automatic push(input int dly, input string name, input logic [1:0] h,
                        input logic [1:0] rl, input logic [1:0] en,
                        input logic [1:0] ly, input logic [1:0] lg, input bit cl);
        exp_t e;
        e.cyc = cyc + dly; e.name = name; e.hpd = h; e.rl = rl; e.en = en;
        e.ly = ly; e.lg = lg; e.chk_led = cl;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare every queued snapshot whose cycle has arrived.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            bit   bad;
            e = sb_q.pop_front();
            n_vec++;
            if (e.cyc < cyc) begin
                n_miss++;
                $display("FAIL %s: snapshot for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else begin
                bad = (hpd !== e.hpd) || (qsfp_resetl !== e.rl) || (enable !== e.en);
                if (e.chk_led) bad = bad || (led_y !== e.ly) || (led_g !== e.lg);
                if (bad) begin
                    n_miss++;
                    $display("FAIL %s @cyc %0d: got hpd=%b rl=%b en=%b y=%b g=%b, want hpd=%b rl=%b en=%b y=%b g=%b (leds checked=%0d)",
                             e.name, cyc, hpd, qsfp_resetl, enable, led_y, led_g,
                             e.hpd, e.rl, e.en, e.ly, e.lg, e.chk_led);
                end
            end
        end
    end

    // Channel 0 insertion trace, offsets 5..16 after modprsl[0] falls: {hpd, resetl, enable, led_y}.
    logic [3:0] ins_tbl [12] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1101,
                                 4'b1100, 4'b1100, 4'b1101, 4'b1101, 4'b1110, 4'b1111};

    initial begin
        rst_n         = 1'b0;
        qsfp_modprsl  = 2'b11;
        reset_request = 2'b00;
        run           = 2'b00;

        // Reset values.
        tick(1);
        push(1, "reset_vals", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        tick(2);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        tick(2);

        // Insertion on channel 0: debounce, RESET for 3, INIT for 5 with blinking yellow, READY.
        for (int k = 0; k < 12; k++) begin
            logic [3:0] r;
            r = ins_tbl[k];
            push(k + 5, $sformatf("insert_ch0_k%0d", k + 5), {1'b0, r[3]}, {1'b0, r[2]},
                 {1'b0, r[1]}, {1'b0, r[0]}, 2'b00, 1'b1);
        end
        qsfp_modprsl[0] = 1'b0;
        tick(17);

        // 3-cycle glitch on channel 1 must not register.
        for (int k = 2; k <= 10; k += 2)
            push(k, $sformatf("glitch_ch1_k%0d", k), 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1);
        qsfp_modprsl[1] = 1'b0;
        tick(3);
        qsfp_modprsl[1] = 1'b1;
        tick(8);

        // run 0->1 in READY: green on, yellow off one cycle later.
        push(1, "run_led", 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1);
        run[0] = 1'b1;
        tick(2);

        // Bring channel 1 to READY.
        push(14, "ch1_init_end", 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        push(16, "ch1_ready", 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 1'b1);
        qsfp_modprsl[1] = 1'b0;
        tick(17);

        // reset_request on channel 1 in READY.
        push(1,  "rreq_reset_start", 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        push(3,  "rreq_reset_last",  2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        push(4,  "rreq_init_start",  2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        push(8,  "rreq_init_last",   2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        push(9,  "rreq_ready",       2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        push(10, "rreq_ready_led",   2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 1'b1);
        reset_request[1] = 1'b1;
        tick(1);
        reset_request[1] = 1'b0;
        tick(10);

        // Align to the blink phase so the removal-vs-request check sees blink=1.
        for (int i = 0; i < 4 && ((cyc - rel_cyc) % 4) != 1; i++) tick(1);

        // Restart of RESET count, then removal colliding with reset_request in INIT.
        push(1,  "restart_reset",   2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        push(4,  "restart_held",    2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        push(5,  "restart_last",    2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        push(6,  "restart_init",    2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        push(8,  "remove_hpd_low",  2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        push(9,  "remove_absent",   2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        push(10, "remove_led_off",  2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1);
        reset_request[1] = 1'b1;
        tick(1);
        reset_request[1] = 1'b0;
        tick(1);
        reset_request[1] = 1'b1;
        qsfp_modprsl[1]  = 1'b1;
        tick(1);
        reset_request[1] = 1'b0;
        tick(5);
        reset_request[1] = 1'b1;
        tick(1);
        reset_request[1] = 1'b0;
        tick(2);

        // Asynchronous reset mid-READY, then the full sequence again on channel 0.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push(0, "async_reset", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        tick(1);
        push(1, "reset_held", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        tick(2);
        rst_n = 1'b1;
        push(5,  "rerun_deb",   2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        push(6,  "rerun_hpd",   2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        push(9,  "rerun_reset", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        push(10, "rerun_init",  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        push(14, "rerun_init2", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        push(15, "rerun_ready", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        push(16, "rerun_led",   2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1);
        tick(17);

        // Drain the scoreboard with a bound.
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick(1);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL %s: never compared (due cycle %0d)", e.name, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish by time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
